// File: rtl/simon_seq_player.sv
// simon_seq_player: plays a stored sequence of 2-bit symbols on a one-hot LED
// display. Each symbol is fetched from an external ROM with a one-clk read
// latency, shown for ON_TICKS tick-high cycles and, when the gap feature is
// built in, followed by a dark gap of OFF_TICKS tick-high cycles.
//
// Build option: define SIMON_SEQ_PLAYER_GAP_EN to include the dark gap (OFF
// state). Without it, a symbol advances straight to the next fetch after its
// ON period and OFF_TICKS only contributes to the tick counter width.
module simon_seq_player #(
    parameter int DEPTH     = 4,
    parameter int AW        = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          start,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] rd_addr,
    input  logic [1:0]    rd_data,
    output logic [3:0]    led,
    output logic          busy,
    output logic          done
);

    localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
`ifdef SIMON_SEQ_PLAYER_GAP_EN
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TICKS - 1);
`endif
    localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ON,
`ifdef SIMON_SEQ_PLAYER_GAP_EN
        S_OFF,
`endif
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] idx, idx_n;
    logic [AW-1:0] len_q, len_n;
    logic [AW-1:0] addr_n;
    logic [1:0]    sym, sym_n;
    logic [3:0]    led_n;
    logic          busy_n, done_n;
    logic          advance;

    // State, datapath and registered outputs; everything clears asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            len_q   <= '0;
            sym     <= '0;
            rd_addr <= '0;
            led     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            len_q   <= len_n;
            sym     <= sym_n;
            rd_addr <= addr_n;
            led     <= led_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state and next-output logic; outputs are derived from the next
    // state so the registered outputs line up with the state they describe.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        len_n   = len_q;
        sym_n   = sym;
        addr_n  = rd_addr;
        advance = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    len_n   = (len > DEPTH_A) ? DEPTH_A : len;
                    idx_n   = '0;
                    addr_n  = '0;
                    state_n = (len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_n = S_LATCH;
            S_LATCH: begin
                sym_n   = rd_data;
                cnt_n   = '0;
                state_n = S_ON;
            end
            S_ON: begin
                if (tick) begin
                    if (cnt == ON_LAST) begin
                        cnt_n = '0;
`ifdef SIMON_SEQ_PLAYER_GAP_EN
                        state_n = S_OFF;
`else
                        advance = 1'b1;
`endif
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
`ifdef SIMON_SEQ_PLAYER_GAP_EN
            S_OFF: begin
                if (tick) begin
                    if (cnt == OFF_LAST) begin
                        cnt_n   = '0;
                        advance = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
`endif
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Finished showing a symbol: either the sequence is complete or the
        // next entry is fetched.
        if (advance) begin
            if (idx + AW'(1) == len_q) begin
                state_n = S_DONE;
            end else begin
                idx_n   = idx + AW'(1);
                addr_n  = idx + AW'(1);
                state_n = S_FETCH;
            end
        end

        led_n  = (state_n == S_ON) ? (4'b0001 << sym_n) : 4'b0000;
        busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_simon_seq_player.sv
// tb_simon_seq_player: self-checking bench for simon_seq_player. A timeline
// model derives, per clock cycle, the expected led/busy/done/rd_addr from the
// playback rules (fetch, latch, lit period, optional gap, done pulse) and the
// pre-generated tick pattern; the DUT is compared against it every cycle.
module tb_simon_seq_player;

    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int ON_T  = 2;
    localparam int OFF_T = 1;
    localparam int MAXC  = 400;
`ifdef SIMON_SEQ_PLAYER_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          start;
    logic [AW-1:0] len;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_data;
    logic [3:0]    led;
    logic          busy;
    logic          done;

    logic [1:0] rom [16];

    int tests = 0;
    int fails = 0;

    // Expected timeline, indexed by cycle number within one playback run.
    // Entry c describes the outputs seen between edge c-1 and edge c.
    bit         tk     [MAXC];
    logic [3:0] e_led  [MAXC];
    bit         e_busy [MAXC];
    bit         e_done [MAXC];
    int         e_addr [MAXC];
    int         n_cyc;
    int         done_cyc;

    always #5 clk = ~clk;

    // External ROM with one clk of read latency.
    always @(posedge clk) rd_data <= rom[rd_addr];

    simon_seq_player #(
        .DEPTH(DEPTH), .AW(AW), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .len(len),
        .rd_addr(rd_addr), .rd_data(rd_data), .led(led), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Build the expected timeline for a start with length l accepted at cycle 0.
    // mode 0: tick every 4th clk, 1: random ticks, 2: tick every clk.
    function automatic void build(input int l, input int mode);
        int L, f, c, cnt;
        logic [3:0] oh;
        for (int i = 0; i < MAXC; i++) begin
            case (mode)
                0:       tk[i] = (i % 4 == 3);
                1:       tk[i] = ($urandom_range(0, 2) == 0);
                default: tk[i] = 1'b1;
            endcase
            e_led[i]  = 4'b0000;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
            e_addr[i] = 0;
        end
        L = (l > DEPTH) ? DEPTH : l;
        f = 1;
        for (int i = 0; i < L; i++) begin
            oh = 4'b0001;
            oh = oh << rom[i];
            for (int k = f; k < f + 2; k++) begin
                e_busy[k] = 1'b1;
                e_addr[k] = i;
            end
            c   = f + 2;
            cnt = 0;
            while (cnt < ON_T && c < MAXC - 8) begin
                e_led[c]  = oh;
                e_busy[c] = 1'b1;
                e_addr[c] = i;
                if (tk[c]) cnt++;
                c++;
            end
            if (GAP) begin
                cnt = 0;
                while (cnt < OFF_T && c < MAXC - 8) begin
                    e_busy[c] = 1'b1;
                    e_addr[c] = i;
                    if (tk[c]) cnt++;
                    c++;
                end
            end
            f = c;
        end
        e_done[f] = 1'b1;
        for (int k = f; k < MAXC; k++) e_addr[k] = (L == 0) ? 0 : L - 1;
        done_cyc = f;
        n_cyc    = f + 3;
    endfunction

    // Run one playback. xmode 0: no extra starts, 1: one extra start at xcyc,
    // 2: random extra starts while busy and always in the done cycle.
    // rst_at >= 0 asserts reset at that cycle and ends the run.
    task automatic run(input string name, input int l, input int mode,
                       input int xmode, input int rst_at);
        int xcyc;
        build(l, mode);
        xcyc = -1;
        if (xmode == 1) begin
            for (int k = 1; k < n_cyc; k++)
                if (xcyc < 0 && e_addr[k] == 1 && e_led[k] != 4'b0000) xcyc = k;
        end
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clk);
            if (c > 0) begin
                check({name, ".led"},  led,  e_led[c]);
                check({name, ".busy"}, busy, e_busy[c]);
                check({name, ".done"}, done, e_done[c]);
                check({name, ".addr"}, rd_addr, e_addr[c]);
                check({name, ".addr_max"}, rd_addr <= AW'(DEPTH - 1), 1);
            end
            if (c == rst_at) begin
                reset = 1'b1;
                start = 1'b0;
                tick  = 1'b0;
                #1;
                check({name, ".rst_led"},  led, 0);
                check({name, ".rst_busy"}, busy, 0);
                check({name, ".rst_done"}, done, 0);
                check({name, ".rst_addr"}, rd_addr, 0);
                @(posedge clk);
                #1;
                check({name, ".rst_hold"}, {led, busy, done}, 0);
                #2 reset = 1'b0;
                return;
            end
            tick  = tk[c];
            start = (c == 0) || (xmode == 1 && c == xcyc) ||
                    (xmode == 2 && c >= 1 && c <= done_cyc &&
                     (c == done_cyc || $urandom_range(0, 1) == 1));
            len   = (c == 0) ? AW'(l) : AW'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        tick  = 1'b0;
        check({name, ".idle_busy"}, busy, 0);
        check({name, ".idle_led"},  led, 0);
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        start = 1'b0;
        len   = '0;
        for (int i = 0; i < 16; i++) rom[i] = 2'($urandom);
        #1;
        check("reset.led",  led, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.addr", rd_addr, 0);
        @(negedge clk);
        reset = 1'b0;

        rom[0] = 2'd2; rom[1] = 2'd0; rom[2] = 2'd3; rom[3] = 2'd1;
        run("seq4", 4, 0, 0, -1);
        run("len0", 0, 0, 0, -1);
        run("len9", 9, 1, 0, -1);
        run("restart_ign", 4, 0, 1, -1);
        run("mid_reset", 4, 0, 0, 4);
        run("after_reset", 4, 0, 0, -1);
        rom[0] = 2'd1; rom[1] = 2'd1;
        run("rom11", 2, 0, 0, -1);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 16; i++) rom[i] = 2'($urandom);
            run("rand", $urandom_range(0, 9), $urandom_range(0, 2),
                ($urandom_range(0, 1) == 1) ? 2 : 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
